// File: rtl/inv_monitor.sv
// Inverter invariant monitor: checks obs_out == ~obs_in delayed by LATENCY cycles,
// counts stimulus toggles and mismatches. Optional macro INV_MONITOR_FIRST_ERR_EN adds first_err_cyc.
module inv_monitor #(
    parameter int unsigned LATENCY = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             obs_in,
    input  logic             obs_out,
    output logic [1:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] tgl_cnt
`ifdef INV_MONITOR_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_cyc
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CHECK   = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [2:0] WARM_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    state_t           cur_st;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] tgl_cnt_q;
    logic [2:0]       wcnt;
    logic             started;
    logic             prev_in;
    logic             dly_bit;
    logic             exp_out;
    logic             checking;
    logic             mismatch;

    // Delay line: dly_bit is obs_in as it was LATENCY edges ago.
    generate
        if (LATENCY == 0) begin : g_nodly
            assign dly_bit = obs_in;
        end else if (LATENCY == 1) begin : g_dly1
            logic dly_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dly_q <= 1'b0;
                else        dly_q <= obs_in;
            end
            assign dly_bit = dly_q;
        end else begin : g_dlyn
            logic [LATENCY-1:0] dly_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dly_q <= '0;
                else        dly_q <= {dly_q[LATENCY-2:0], obs_in};
            end
            assign dly_bit = dly_q[LATENCY-1];
        end
    endgenerate

    assign exp_out  = ~dly_bit;
    assign checking = (cur_st == CHECK) || (cur_st == ST_FAIL);
    assign mismatch = checking && (obs_out != exp_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_in <= 1'b0;
        else        prev_in <= obs_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st    <= IDLE;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            tgl_cnt_q <= '0;
            wcnt      <= '0;
            started   <= 1'b0;
        end else if (clr) begin
            cur_st    <= IDLE;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            tgl_cnt_q <= '0;
            wcnt      <= '0;
            started   <= 1'b0;
        end else if (!en) begin
            cur_st  <= IDLE;
            wcnt    <= '0;
            started <= 1'b0;
        end else begin
            case (cur_st)
                IDLE: begin
                    cur_st  <= (LATENCY > 0) ? WARMUP : CHECK;
                    wcnt    <= '0;
                    started <= 1'b0;
                end
                WARMUP: begin
                    if (wcnt == WARM_LAST) begin
                        cur_st <= CHECK;
                        wcnt   <= '0;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                CHECK, ST_FAIL: begin
                    if (mismatch) begin
                        cur_st <= ST_FAIL;
                        err_q  <= 1'b1;
                        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
                    end
                    // The first checking cycle has no valid previous sample to toggle against.
                    if (started && (obs_in != prev_in) && (tgl_cnt_q != '1))
                        tgl_cnt_q <= tgl_cnt_q + CNT_W'(1);
                    started <= 1'b1;
                end
                default: cur_st <= IDLE;
            endcase
        end
    end

`ifdef INV_MONITOR_FIRST_ERR_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] first_err_q;

    // cyc_q reads 0 during the first checking cycle; err_q low marks "no error latched yet".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q       <= '0;
            first_err_q <= '1;
        end else if (clr) begin
            cyc_q       <= '0;
            first_err_q <= '1;
        end else if (!en || !checking) begin
            cyc_q <= '0;
        end else begin
            if (cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
            if (mismatch && !err_q) first_err_q <= cyc_q;
        end
    end

    assign first_err_cyc = first_err_q;
`endif

    assign state   = cur_st;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign tgl_cnt = tgl_cnt_q;

endmodule

// File: tb/tb_inv_monitor.sv
// Scoreboard bench for inv_monitor: three instances (LATENCY 0/2/1) driven from one obs_in stream.
module tb_inv_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic obs_in = 1'b0;
    logic en_a = 1'b0, clr_a = 1'b0, out_a = 1'b0;
    logic en_b = 1'b0, clr_b = 1'b0, out_b = 1'b0;
    logic en_c = 1'b0, clr_c = 1'b0, out_c = 1'b0;

    logic [1:0]  state_a, state_b, state_c;
    logic        err_a, err_b, err_c;
    logic [15:0] ecnt_a, tcnt_a, ecnt_b, tcnt_b;
    logic [3:0]  ecnt_c, tcnt_c;
`ifdef INV_MONITOR_FIRST_ERR_EN
    logic [15:0] ferr_a, ferr_b;
    logic [3:0]  ferr_c;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] hist_tb = '0;

    always #5 clk = ~clk;

    inv_monitor #(.LATENCY(0), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .clr(clr_a), .obs_in(obs_in), .obs_out(out_a),
        .state(state_a), .err(err_a), .err_cnt(ecnt_a), .tgl_cnt(tcnt_a)
`ifdef INV_MONITOR_FIRST_ERR_EN
        , .first_err_cyc(ferr_a)
`endif
    );
    inv_monitor #(.LATENCY(2), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .clr(clr_b), .obs_in(obs_in), .obs_out(out_b),
        .state(state_b), .err(err_b), .err_cnt(ecnt_b), .tgl_cnt(tcnt_b)
`ifdef INV_MONITOR_FIRST_ERR_EN
        , .first_err_cyc(ferr_b)
`endif
    );
    inv_monitor #(.LATENCY(1), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .clr(clr_c), .obs_in(obs_in), .obs_out(out_c),
        .state(state_c), .err(err_c), .err_cnt(ecnt_c), .tgl_cnt(tcnt_c)
`ifdef INV_MONITOR_FIRST_ERR_EN
        , .first_err_cyc(ferr_c)
`endif
    );

    typedef struct {
        logic [1:0]  st;
        logic        err;
        int unsigned ecnt, tcnt, wcnt, cyc, ferr;
        logic        prev, started;
        logic [7:0]  hist;
    } mdl_t;

    typedef struct {
        int          id;
        logic [1:0]  st;
        logic        err;
        int unsigned ecnt, tcnt, ferr;
    } exp_t;

    mdl_t ma, mb, mc;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, want, $time);
        end
    endtask

    function automatic mdl_t mreset(int unsigned maxv);
        mdl_t m;
        m.st = 2'd0; m.err = 1'b0; m.ecnt = 0; m.tcnt = 0; m.wcnt = 0; m.cyc = 0;
        m.ferr = maxv; m.prev = 1'b0; m.started = 1'b0; m.hist = '0;
        return m;
    endfunction

    // Behavioural model of one clock edge.
    function automatic mdl_t step(mdl_t m, logic en, logic clr, logic in, logic out,
                                  int unsigned lat, int unsigned maxv);
        mdl_t n;
        logic e;
        n = m;
        e = ~in;
        if (lat > 0) e = ~m.hist[lat-1];
        n.hist = {m.hist[6:0], in};
        n.prev = in;
        if (clr) begin
            n.st = 2'd0; n.err = 1'b0; n.ecnt = 0; n.tcnt = 0; n.wcnt = 0;
            n.started = 1'b0; n.cyc = 0; n.ferr = maxv;
        end else if (!en) begin
            n.st = 2'd0; n.wcnt = 0; n.started = 1'b0; n.cyc = 0;
        end else if (m.st == 2'd0) begin
            n.st = (lat > 0) ? 2'd1 : 2'd2; n.wcnt = 0; n.started = 1'b0; n.cyc = 0;
        end else if (m.st == 2'd1) begin
            n.cyc = 0;
            if (m.wcnt == lat - 1) begin n.st = 2'd2; n.wcnt = 0; end
            else n.wcnt = m.wcnt + 1;
        end else begin
            if (out !== e) begin
                n.st = 2'd3; n.err = 1'b1;
                if (m.ecnt < maxv) n.ecnt = m.ecnt + 1;
                if (!m.err) n.ferr = m.cyc;
            end
            if (m.started && (in != m.prev) && (m.tcnt < maxv)) n.tcnt = m.tcnt + 1;
            n.started = 1'b1;
            if (m.cyc < maxv) n.cyc = m.cyc + 1;
        end
        return n;
    endfunction

    function automatic exp_t to_exp(int id, mdl_t m);
        exp_t e;
        e.id = id; e.st = m.st; e.err = m.err; e.ecnt = m.ecnt; e.tcnt = m.tcnt; e.ferr = m.ferr;
        return e;
    endfunction

    task automatic cmp(input exp_t e);
        case (e.id)
            0: begin
                chk("a.state", 32'(state_a), 32'(e.st)); chk("a.err", 32'(err_a), 32'(e.err));
                chk("a.err_cnt", 32'(ecnt_a), e.ecnt);   chk("a.tgl_cnt", 32'(tcnt_a), e.tcnt);
`ifdef INV_MONITOR_FIRST_ERR_EN
                chk("a.first_err_cyc", 32'(ferr_a), e.ferr);
`endif
            end
            1: begin
                chk("b.state", 32'(state_b), 32'(e.st)); chk("b.err", 32'(err_b), 32'(e.err));
                chk("b.err_cnt", 32'(ecnt_b), e.ecnt);   chk("b.tgl_cnt", 32'(tcnt_b), e.tcnt);
`ifdef INV_MONITOR_FIRST_ERR_EN
                chk("b.first_err_cyc", 32'(ferr_b), e.ferr);
`endif
            end
            default: begin
                chk("c.state", 32'(state_c), 32'(e.st)); chk("c.err", 32'(err_c), 32'(e.err));
                chk("c.err_cnt", 32'(ecnt_c), e.ecnt);   chk("c.tgl_cnt", 32'(tcnt_c), e.tcnt);
`ifdef INV_MONITOR_FIRST_ERR_EN
                chk("c.first_err_cyc", 32'(ferr_c), e.ferr);
`endif
            end
        endcase
    endtask

    task automatic tick();
        exp_t e;
        ma = step(ma, en_a, clr_a, obs_in, out_a, 0, 16'hFFFF);
        mb = step(mb, en_b, clr_b, obs_in, out_b, 2, 16'hFFFF);
        mc = step(mc, en_c, clr_c, obs_in, out_c, 1, 15);
        sb.push_back(to_exp(0, ma));
        sb.push_back(to_exp(1, mb));
        sb.push_back(to_exp(2, mc));
        @(posedge clk);
        #1;
        hist_tb = {hist_tb[6:0], obs_in};
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e);
        end
    endtask

    task automatic chk_all_reset();
        chk("rst.a.state", 32'(state_a), 0); chk("rst.a.err", 32'(err_a), 0);
        chk("rst.a.err_cnt", 32'(ecnt_a), 0); chk("rst.a.tgl_cnt", 32'(tcnt_a), 0);
        chk("rst.b.state", 32'(state_b), 0); chk("rst.b.err", 32'(err_b), 0);
        chk("rst.c.state", 32'(state_c), 0); chk("rst.c.err", 32'(err_c), 0);
        chk("rst.c.err_cnt", 32'(ecnt_c), 0); chk("rst.c.tgl_cnt", 32'(tcnt_c), 0);
`ifdef INV_MONITOR_FIRST_ERR_EN
        chk("rst.c.first_err_cyc", 32'(ferr_c), 15);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ma = mreset(16'hFFFF); mb = mreset(16'hFFFF); mc = mreset(15);
        #1;
        chk_all_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ideal inverter, LATENCY=0: 20 checked samples toggling every 2 cycles.
        en_a = 1'b1; obs_in = 1'b0; out_a = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            obs_in = ((k / 2) % 2) != 0; out_a = ~obs_in;
            tick();
        end
        chk("ideal.tgl_cnt", 32'(tcnt_a), 9);
        chk("ideal.state", 32'(state_a), 2);
        chk("ideal.err_cnt", 32'(ecnt_a), 0);

        // Stuck-at-0 output; obs_in low at check cycle 3, 5 and 6.
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        obs_in = 1'b1; out_a = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            obs_in = !(k == 3 || k == 5 || k == 6); out_a = 1'b0;
            tick();
            if (k == 3) begin
                chk("stuck.err", 32'(err_a), 1);
                chk("stuck.state", 32'(state_a), 3);
                chk("stuck.first_cnt", 32'(ecnt_a), 1);
            end
        end
        chk("stuck.err_cnt", 32'(ecnt_a), 3);
`ifdef INV_MONITOR_FIRST_ERR_EN
        chk("stuck.first_err_cyc", 32'(ferr_a), 3);
`endif

        // Latency: response is ~obs_in delayed 2; B (LATENCY=2) passes, C (LATENCY=1) fails.
        en_b = 1'b1; en_c = 1'b1;
        for (int k = 0; k < 16; k++) begin
            obs_in = ((k / 3) % 2) != 0;
            out_a = ~obs_in; out_b = ~hist_tb[1]; out_c = ~hist_tb[1];
            tick();
            if (k < 2) chk("lat.warmup", 32'(state_b), 1);
            if (k == 2) chk("lat.check", 32'(state_b), 2);
        end
        chk("lat2.err", 32'(err_b), 0);
        chk("lat1.err", 32'(err_c), 1);

        // Clear wins over a simultaneous mismatch, then checking resumes.
        out_a = obs_in; out_b = ~hist_tb[1]; out_c = ~hist_tb[1]; clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("clr.err", 32'(err_a), 0);
        chk("clr.err_cnt", 32'(ecnt_a), 0);
        chk("clr.state", 32'(state_a), 0);
        for (int k = 0; k < 4; k++) begin
            obs_in = k[0]; out_a = ~obs_in; out_b = ~hist_tb[1]; out_c = ~hist_tb[1];
            tick();
        end
        out_a = obs_in; out_b = ~hist_tb[1]; out_c = ~hist_tb[1];
        tick();
        chk("resume.err", 32'(err_a), 1);
        chk("resume.err_cnt", 32'(ecnt_a), 1);

        // Saturation on CNT_W=4: toggle every cycle with a non-inverted delayed response.
        out_a = ~obs_in; out_b = ~hist_tb[1]; out_c = hist_tb[0]; clr_c = 1'b1;
        tick();
        clr_c = 1'b0;
        for (int k = 0; k < 25; k++) begin
            obs_in = (k % 2) != 0;
            out_a = ~obs_in; out_b = ~hist_tb[1]; out_c = hist_tb[0];
            tick();
        end
        chk("sat.err_cnt", 32'(ecnt_c), 15);
        chk("sat.tgl_cnt", 32'(tcnt_c), 15);
        chk("sat.state", 32'(state_c), 3);

        // Asynchronous reset between edges while C is in FAIL.
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_reset();
        ma = mreset(16'hFFFF); mb = mreset(16'hFFFF); mc = mreset(15);
        hist_tb = '0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            obs_in = k[0]; out_a = ~obs_in; out_b = 1'b0; out_c = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_monitor.md
Name: inv_monitor

Overview:
- Observer at the receiving end of an inverter's in/out pair. It samples the stimulus (obs_in) and the response (obs_out) on every clock and checks the invariant obs_out == ~obs_in, compensating for a configurable DUT latency.
- It counts stimulus toggles and mismatches and raises a sticky error flag.
- Instantiated beside an inverter DUT in benches and in on-board self-check wrappers.

Parameters:
- LATENCY, 0, DUT response delay in clk cycles (0..7); 0 = combinational DUT.
- CNT_W, 16, width of the toggle and error counters.

Ports:
- clk  input  1  sampling clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  monitor enable; 1 = run, 0 = return to IDLE.
- clr  input  1  synchronous clear of counters, flags and FSM (FSM goes to IDLE).
- obs_in  input  1  observed inverter input.
- obs_out  input  1  observed inverter output.
- state  output  2  FSM state: 0 IDLE, 1 WARMUP, 2 CHECK, 3 FAIL.
- err  output  1  sticky mismatch flag.
- err_cnt  output  CNT_W  number of mismatching samples, saturating.
- tgl_cnt  output  CNT_W  number of obs_in transitions while checking, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, err=0, err_cnt=0, tgl_cnt=0.
  - Delay line and the previous-obs_in register are cleared to 0.
  - Reset asserted mid-run aborts immediately; no partial counts are retained.
- Delay line:
  - LATENCY-deep shift register of obs_in, shifting every clk in every state.
  - exp = ~(obs_in delayed by LATENCY cycles). For LATENCY=0, exp = ~obs_in in the same cycle.
- FSM, evaluated on the rising edge of clk:
  - IDLE: counters hold. If en=1, go to WARMUP when LATENCY>0, else go directly to CHECK.
  - WARMUP: a warmup counter counts LATENCY cycles, then the FSM goes to CHECK. No comparisons are made in this state.
  - CHECK: compare obs_out against exp every cycle.
    - Mismatch: err_cnt+1, err<=1, next state FAIL.
    - Toggle (obs_in differs from its value in the previous cycle): tgl_cnt+1. The first CHECK cycle does not count as a toggle.
  - FAIL: comparison and counting continue exactly as in CHECK. FAIL is left only by clr, en=0, or reset.
  - en=0 in any state: go to IDLE next cycle. err and counters hold their values.
- Control priority: rst_n > clr > en.
  - clr=1: counters=0, err=0, state=IDLE, warmup counter=0.
  - clr and a mismatch in the same cycle: clr wins, and the mismatch is not counted.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Outputs are registered; a mismatch sampled at edge N is visible on err/err_cnt after edge N.
- Toggle and mismatch in the same cycle: both counters increment.

Optional Feature:
- Macro: INV_MONITOR_FIRST_ERR_EN.
- Defined:
  - Adds output first_err_cyc [CNT_W-1:0], a free-running cycle counter value latched on the first mismatch after reset or clr.
  - The cycle counter starts at 0 on entry to CHECK and saturates.
  - first_err_cyc resets to all-ones, meaning no error recorded.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Ideal inverter, LATENCY=0:
  - Stimulus: en=1, obs_in toggles every 2 cycles for 20 cycles, obs_out=~obs_in.
  - Required: state=CHECK, err=0, err_cnt=0, tgl_cnt=9.
- Stuck-at-0 output, LATENCY=0:
  - Stimulus: obs_out=0 while obs_in=0 at cycle 3.
  - Required: err=1 and state=FAIL after that edge, err_cnt increments once for each further obs_in=0 sample.
  - With the macro defined: first_err_cyc=3.
- Latency compensation, LATENCY=2:
  - Stimulus: obs_out equals ~obs_in delayed 2 cycles.
  - Required: WARMUP lasts 2 cycles, then CHECK with err=0. Same stimulus with LATENCY=1 gives err=1.
- Clear versus error:
  - Stimulus: clr=1 in the same cycle as a mismatch.
  - Required: err=0, err_cnt=0, state=IDLE next cycle. Re-enabling resumes checking.
- Saturation, CNT_W=4:
  - Stimulus: 20 consecutive mismatches.
  - Required: err_cnt stops at 15 and does not wrap. A toggle stream saturates tgl_cnt at 15 likewise.
- Async reset mid-FAIL:
  - Stimulus: drop rst_n between clock edges.
  - Required: all outputs return to their reset values immediately, without waiting for a clock edge.
